// File: rtl/alu_shl_seq.sv
// -----------------------------------------------------------------------------
// alu_shl_seq
//
// Multi-cycle left shifter / rotator for the datapath ALU. Ra is shifted left
// by Rb[SHAMT_W-1:0] positions at one bit position per clock.
//
// Optional feature macro: ALU_ROL_EN
//   defined   : op selects SHL (0) or ROL (1), captured on an accepted start.
//   undefined : op is ignored, every operation is a logical left shift and no
//               rotate feedback mux exists. The port list is the same.
//
// Ports:
//   clock  in   system clock, all state updates on rising edge
//   clear  in   synchronous active-low reset
//   start  in   operation request, sampled only in IDLE or DONE
//   op     in   0 = SHL (zero fill), 1 = ROL (only with ALU_ROL_EN)
//   Ra     in   operand, captured on accepted start
//   Rb     in   shift amount in Rb[SHAMT_W-1:0], captured on accepted start
//   Rz     out  result register
//   cout   out  last bit shifted out of bit WIDTH-1 (0 when amount is 0)
//   busy   out  high while shifting
//   done   out  one-cycle pulse, Rz/cout valid
//
// Handshake: start is accepted on a rising edge only when the FSM is in IDLE
// or DONE; while busy is high start is ignored (no queueing). done is a
// single-cycle pulse after which Rz and cout hold until the next accepted
// start. A start seen in DONE is accepted immediately, with no idle bubble.
// -----------------------------------------------------------------------------
module alu_shl_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   Ra,
    input  logic [WIDTH-1:0]   Rb,
    output logic [WIDTH-1:0]   Rz,
    output logic               cout,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // state_q is kept as a plain named register so checkers can bind to it.
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     rz_q, rz_d;
    logic                 cout_q, cout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [SHAMT_W-1:0]   count_q, count_d;
    logic                 op_r;
    logic                 fill_bit;

    logic [SHAMT_W-1:0]   rb_amount;
    assign rb_amount = Rb[SHAMT_W-1:0];

`ifdef ALU_ROL_EN
    logic op_r_q, op_r_d;
    assign op_r = op_r_q;
    // Rotate feeds the outgoing MSB back into bit 0; shift fills with zero.
    assign fill_bit = op_r_q ? rz_q[WIDTH-1] : 1'b0;
    logic unused_bits;
    assign unused_bits = ^Rb[WIDTH-1:SHAMT_W];
`else
    assign op_r     = 1'b0;
    assign fill_bit = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{Rb[WIDTH-1:SHAMT_W], op, op_r};
`endif

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        rz_d    = rz_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        count_d = count_q;
`ifdef ALU_ROL_EN
        op_r_d  = op_r_q;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rz_d    = Ra;
                    count_d = rb_amount;
                    cout_d  = 1'b0;
`ifdef ALU_ROL_EN
                    op_r_d  = op;
`endif
                    if (rb_amount == '0) begin
                        // Zero amount completes without entering SHIFT.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                cout_d  = rz_q[WIDTH-1];
                rz_d    = {rz_q[WIDTH-2:0], fill_bit};
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            rz_q    <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rz_q    <= rz_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

`ifdef ALU_ROL_EN
    always_ff @(posedge clock) begin
        if (!clear) begin
            op_r_q <= 1'b0;
        end else begin
            op_r_q <= op_r_d;
        end
    end
`endif

    assign Rz   = rz_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_shl_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_shl_seq
//
// Directed bench for alu_shl_seq: a table of operations with hand-computed
// results, followed by hand-written sequences for reset, start-while-busy,
// back-to-back starts and reset in the middle of a shift.
// -----------------------------------------------------------------------------
module tb_alu_shl_seq;

    localparam int W = 32;

    logic          clock;
    logic          clear;
    logic          start;
    logic          op;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic [W-1:0]  rz;
    logic          cout;
    logic          busy;
    logic          done;

    int n_vec;
    int n_bad;

    logic [W-1:0] exp_q[$];

    alu_shl_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .op    (op),
        .Ra    (ra),
        .Rb    (rb),
        .Rz    (rz),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         op;
        logic [W-1:0] exp_rz;
        logic         exp_cout;
        int           exp_busy;
    } vec_t;

    vec_t vecs[8];

    // Drive one operation and measure it. Inputs are scrambled right after
    // acceptance to show they were captured.
    task automatic run_op(input vec_t v, input int idx);
        int busy_cnt;
        logic seen;
        logic [W-1:0] exp_rz;
        busy_cnt = 0;
        seen = 1'b0;
        exp_q.push_back(v.exp_rz);
        @(negedge clock);
        start = 1'b1;
        ra    = v.ra;
        rb    = v.rb;
        op    = v.op;
        @(negedge clock);
        start = 1'b0;
        ra    = $urandom;
        rb    = $urandom;
        op    = 1'($urandom_range(0, 1));
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clock);
        end
        check($sformatf("v%0d done_seen", idx), W'(seen), W'(1));
        exp_rz = exp_q.pop_front();
        check($sformatf("v%0d rz", idx), rz, exp_rz);
        check($sformatf("v%0d cout", idx), W'(cout), W'(v.exp_cout));
        check($sformatf("v%0d busy_cycles", idx), W'(busy_cnt), W'(v.exp_busy));
        @(negedge clock);
        check($sformatf("v%0d done_pulse_width", idx), W'(done), W'(0));
        check($sformatf("v%0d rz_hold", idx), rz, exp_rz);
    endtask

    // Wait up to a bound for done; returns the number of negedges waited.
    task automatic wait_done(output int cyc, output logic seen);
        cyc = 0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            cyc++;
            @(negedge clock);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int cyc;
        logic seen;
        logic done_ever;

        n_vec = 0;
        n_bad = 0;
        clear = 1'b0;
        start = 1'b1;
        op    = 1'b0;
        ra    = 32'hFFFF_FFFF;
        rb    = 32'd5;

        vecs[0] = '{32'h0000_0001, 32'd4,          1'b0, 32'h0000_0010, 1'b0, 4};
        vecs[1] = '{32'h8000_0001, 32'd0,          1'b0, 32'h8000_0001, 1'b0, 0};
        vecs[2] = '{32'hFFFF_FFFF, 32'd31,         1'b0, 32'h8000_0000, 1'b1, 31};
`ifdef ALU_ROL_EN
        vecs[3] = '{32'h8000_0003, 32'd1,          1'b1, 32'h0000_0007, 1'b1, 1};
        vecs[7] = '{32'hF000_0001, 32'd4,          1'b1, 32'h0000_001F, 1'b1, 4};
`else
        vecs[3] = '{32'h8000_0003, 32'd1,          1'b1, 32'h0000_0006, 1'b1, 1};
        vecs[7] = '{32'hF000_0001, 32'd4,          1'b1, 32'h0000_0010, 1'b1, 4};
`endif
        vecs[4] = '{32'h1234_5678, 32'd8,          1'b0, 32'h3456_7800, 1'b0, 8};
        vecs[5] = '{32'h0F00_0000, 32'd5,          1'b0, 32'hE000_0000, 1'b1, 5};
        vecs[6] = '{32'h0000_00FF, 32'hFFFF_FFE3,  1'b0, 32'h0000_07F8, 1'b0, 3};

        // Reset held for two cycles with start asserted: nothing may start.
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("reset_rz", rz, '0);
            check("reset_busy", W'(busy), W'(0));
            check("reset_done", W'(done), W'(0));
            check("reset_cout", W'(cout), W'(0));
        end
        start = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        check("post_reset_busy", W'(busy), W'(0));
        check("post_reset_done", W'(done), W'(0));
        check("post_reset_rz", rz, '0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], i);
        end

        // start pulsed mid-shift with different operands is ignored.
        @(negedge clock);
        start = 1'b1; ra = 32'h0000_0001; rb = 32'd4; op = 1'b0;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1; ra = 32'h0000_FFFF; rb = 32'd1;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc, seen);
        check("midstart_done_seen", W'(seen), W'(1));
        check("midstart_wait", W'(cyc), W'(2));
        check("midstart_rz", rz, 32'h0000_0010);
        check("midstart_cout", W'(cout), W'(0));
        @(negedge clock);
        check("midstart_idle", W'(busy | done), W'(0));

        // start held through DONE: second op accepted without an idle gap.
        start = 1'b1; ra = 32'h0000_0001; rb = 32'd2; op = 1'b0;
        @(negedge clock);
        wait_done(cyc, seen);
        check("b2b_first_done", W'(seen), W'(1));
        check("b2b_first_rz", rz, 32'h0000_0004);
        ra = 32'h0000_0003; rb = 32'd3;
        @(negedge clock);
        start = 1'b0;
        check("b2b_no_gap_busy", W'(busy), W'(1));
        check("b2b_no_gap_done", W'(done), W'(0));
        wait_done(cyc, seen);
        check("b2b_second_done", W'(seen), W'(1));
        check("b2b_second_spacing", W'(cyc + 1), W'(4));
        check("b2b_second_rz", rz, 32'h0000_0018);
        @(negedge clock);

        // Reset after five shift cycles discards the operation.
        start = 1'b1; ra = 32'h0000_0001; rb = 32'd20;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clock);
        check("midreset_pre_rz", rz, 32'h0000_0020);
        check("midreset_pre_busy", W'(busy), W'(1));
        clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        check("midreset_rz", rz, '0);
        check("midreset_busy", W'(busy), W'(0));
        check("midreset_done", W'(done), W'(0));
        check("midreset_cout", W'(cout), W'(0));
        done_ever = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done || busy) done_ever = 1'b1;
        end
        check("midreset_no_done", W'(done_ever), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_shl_seq.md
Name: alu_shl_seq

Overview:
- Multi-cycle left shifter/rotator for the datapath ALU.
- Shifts Ra left by Rb[4:0] positions, one bit position per clock.
- Start/busy/done handshake; the control unit stalls on busy and latches Rz on done.
- Left-direction counterpart to the combinational arithmetic-right shifter. The shift amount is the full 5 bits (0..31).

Parameters:
- WIDTH, 32, datapath width of Ra, Rz.
- SHAMT_W, 5, width of shift-amount field taken from Rb[SHAMT_W-1:0].

Ports:
- clock  input  1  system clock, all state updates on rising edge
- clear  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  1  0 = SHL (logical left, zero fill), 1 = ROL (rotate left); used only with ALU_ROL_EN
- Ra  input  WIDTH  operand, captured on accepted start
- Rb  input  WIDTH  shift amount in Rb[SHAMT_W-1:0]; upper bits ignored; captured on accepted start
- Rz  output  WIDTH  result register
- cout  output  1  last bit shifted/rotated out of bit WIDTH-1; 0 when amount = 0
- busy  output  1  high while shifting
- done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset: clear=0 at a rising edge forces state=IDLE, Rz=0, cout=0, busy=0, done=0, count=0, op_r=0. Applies from any state, including mid-shift; the in-flight operation is discarded and no done is issued.
- States: IDLE, SHIFT, DONE.
- Start accept: start=1 in IDLE or DONE at an edge loads Rz<=Ra, count<=Rb[4:0], op_r<=op, cout<=0.
  - count=0: next state DONE.
  - count>0: next state SHIFT, busy=1.
- SHIFT, each edge:
  - SHL: cout<=Rz[WIDTH-1]; Rz<={Rz[WIDTH-2:0],1'b0}.
  - ROL: cout<=Rz[WIDTH-1]; Rz<={Rz[WIDTH-2:0],Rz[WIDTH-1]}.
  - count<=count-1.
  - When count=1, next state DONE and busy drops.
- start while in SHIFT is ignored; no queueing.
- DONE: done=1 for exactly one cycle; Rz and cout are valid.
  - Next edge: start=1 accepts a new operation (back-to-back, no idle bubble); otherwise go to IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+max(N,1)-… i.e. the cycle after edge k+N for N≥1, and the cycle after edge k for N=0.
  - N=31: busy for 31 cycles, done in cycle 32 after the start edge.
- Rz and cout hold their values in IDLE and DONE until the next accepted start. Ra and Rb may change freely after acceptance.
- Arithmetic:
  - SHL result = (Ra << N) truncated to WIDTH.
  - N=0 returns Ra unchanged with cout=0.
  - Amounts ≥ WIDTH cannot occur with the default parameters.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ALU_ROL_EN.
- Defined: op is captured and ROL is supported as described.
- Undefined:
  - op is ignored and op_r is tied to 0; every operation is SHL.
  - No rotate feedback mux is synthesised.
  - Ports are unchanged.

Test Plan:
- Reset: clear=0 for 2 cycles with start=1, Ra=32'hFFFFFFFF -> Rz=0, busy=0, done=0, cout=0 throughout; no operation starts.
- SHL: Ra=32'h0000_0001, Rb=4, op=0, start 1 cycle -> busy high 4 cycles; done pulse in cycle 5; Rz=32'h0000_0010, cout=0.
- Boundary amounts:
  - Ra=32'h8000_0001, Rb=0 -> done the cycle after start, busy never high, Rz=32'h8000_0001, cout=0.
  - Ra=32'hFFFF_FFFF, Rb=31 -> busy 31 cycles; Rz=32'h8000_0000, cout=1.
- ROL (ALU_ROL_EN defined): Ra=32'h8000_0003, Rb=1, op=1 -> Rz=32'h0000_0007, cout=1. Same stimulus with the macro undefined -> Rz=32'h0000_0006, cout=1.
- Handshake:
  - start pulsed mid-SHIFT with a different Ra -> ignored; the original result completes.
  - start held high through DONE -> the second op is accepted on the DONE edge; the second done follows N2+1 cycles later with no IDLE gap.
- Reset mid-op: Ra=32'h1, Rb=20, assert clear=0 after 5 shift cycles -> next cycle state IDLE, Rz=0, busy=0; no done pulse ever appears for that op.
